// File: rtl/core_pipe_ctrl_pkg.sv
// rtl/core_pipe_ctrl_pkg.sv - watchdog state encodings and register-index constants
package core_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN  = 2'd0,
    PC_HOLD = 2'd1,
    PC_TRIP = 2'd2
  } wdog_state_t;

  localparam int REG_X0 = 0;

endpackage

// File: rtl/core_sat_cnt.sv
// rtl/core_sat_cnt.sv - saturating up-counter; EN=0 builds no flops and ties cnt to 0
module core_sat_cnt #(
  parameter int W  = 32,
  parameter bit EN = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  generate
    if (EN) begin : g_cnt
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
        end else if (inc && (cnt != '1)) begin
          cnt <= cnt + W'(1);
        end
      end
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clock, reset, inc};
      assign cnt = '0;
    end
  endgenerate

endmodule

// File: rtl/core_pipe_ctrl.sv
// rtl/core_pipe_ctrl.sv - pipeline valid chain, load-use/flush/freeze control, freeze watchdog
// Perf counters are built only when CORE_PIPE_PERF_EN is defined.
module core_pipe_ctrl
  import core_pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_write_sel,
  input  logic                  ex_is_load,
  input  logic                  br_en,
  input  logic                  dcache_stall,
  output logic                  stall_fd,
  output logic                  bubble_a,
  output logic                  flush_f,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  retire,
  output logic                  wdog_trip,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      ret_cnt,
  output logic [CNT_W-1:0]      stl_cnt
);

  localparam int FCNT_W = $clog2(WDOG_CYCLES + 1);

`ifdef CORE_PIPE_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic                  freeze;
  logic                  hz;
  logic                  flush;
  logic [NUM_STAGES-1:0] v;
  wdog_state_t           state;
  logic [FCNT_W-1:0]     fcnt;

  // Gating with reset keeps every combinational output at 0 while reset is held.
  assign freeze = dcache_stall & reset;
  assign hz     = v[1] & v[2] & ex_is_load & (ex_write_sel != REG_ADDR_W'(REG_X0)) &
                  ((dec_use_rs1 & (dec_rs1 == ex_write_sel)) |
                   (dec_use_rs2 & (dec_rs2 == ex_write_sel)));
  assign flush  = br_en & v[1] & ~hz;

  assign stall_fd    = freeze | hz;
  assign bubble_a    = ~freeze & hz;
  assign flush_f     = ~freeze & flush;
  assign retire      = v[NUM_STAGES-1] & ~freeze;
  assign stage_valid = v;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v <= '0;
    end else if (freeze) begin
      v <= v;
    end else if (hz) begin
      v[2]              <= 1'b0;
      v[NUM_STAGES-1:3] <= v[NUM_STAGES-2:2];
    end else begin
      v[0]              <= fetch_valid;
      v[1]              <= v[0] & ~flush;
      v[NUM_STAGES-1:2] <= v[NUM_STAGES-2:1];
    end
  end

  // fcnt counts consecutive frozen edges; TRIP is left only through reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= PC_RUN;
      fcnt      <= '0;
      wdog_trip <= 1'b0;
    end else begin
      case (state)
        PC_RUN: begin
          if (freeze) begin
            state <= PC_HOLD;
            fcnt  <= FCNT_W'(1);
          end
        end
        PC_HOLD: begin
          if (!freeze) begin
            state <= PC_RUN;
            fcnt  <= '0;
          end else if (fcnt == FCNT_W'(WDOG_CYCLES - 1)) begin
            state     <= PC_TRIP;
            wdog_trip <= 1'b1;
          end else begin
            fcnt <= fcnt + FCNT_W'(1);
          end
        end
        PC_TRIP: begin
          wdog_trip <= 1'b1;
        end
        default: begin
          state <= PC_RUN;
          fcnt  <= '0;
        end
      endcase
    end
  end

  core_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_cyc_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .cnt   (cyc_cnt)
  );

  core_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_ret_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (retire),
    .cnt   (ret_cnt)
  );

  core_sat_cnt #(.W(CNT_W), .EN(PERF_EN)) u_stl_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_fd),
    .cnt   (stl_cnt)
  );

endmodule
